// File: rtl/apb_pkg.sv
// Shared types and defaults for the APB master bridge.
// Imported by the interface, the bridge FSM and the optional wait timer.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
  } apb_rsp_t;

  // APB transfers are word-sized; any nonzero byte offset is rejected.
  function automatic logic addr_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/apb_master_bridge_if.sv
// Requester port (valid/ready request + response) and APB3 bus signals.
// master modport is the bridge side; slave modport is the requester/APB-slave side.
interface apb_master_bridge_if
  import apb_pkg::*;
#(
  parameter int ADDR_W = APB_ADDR_W,
  parameter int DATA_W = APB_DATA_W
);

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  PRDATA, PREADY, PSLVERR,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output PRDATA, PREADY, PSLVERR,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

endinterface

// File: rtl/apb_wait_timer.sv
// ACCESS wait-state timer: loaded in SETUP, counts down on each wait cycle.
// Only instantiated when APB_MASTER_TIMEOUT_EN is defined.
module apb_wait_timer
  import apb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk_sys,
  input  logic rst,
  input  logic load,
  input  logic wait_cycle,
  output logic timeout
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counting down from TIMEOUT_CYCLES-1 reaches zero on the same wait cycle
  // an up-counter would reach TIMEOUT_CYCLES-1.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (wait_cycle && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout = wait_cycle && (cnt_q == '0);

endmodule

// File: rtl/apb_master_bridge.sv
// Valid/ready request port to APB3 master bridge, one transfer in flight.
// Optional ACCESS timeout enabled by defining APB_MASTER_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | req_ready=1, waiting for a request
// SETUP  | PSEL=1, PENABLE=0 for exactly one cycle
// ACCESS | PSEL=1, PENABLE=1 until PREADY (or timeout)
// RESP   | rsp_valid=1 held until rsp_ready
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic                 PCLK,
  input logic                 PRESET,
  apb_master_bridge_if.master bus
);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_SETUP  = SETUP;
  localparam logic [1:0] S_ACCESS = ACCESS;
  localparam logic [1:0] S_RESP   = RESP;

  logic [1:0]        state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              timeout_hit;

`ifdef APB_MASTER_TIMEOUT_EN
  apb_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk_sys    (PCLK),
    .rst        (PRESET),
    .load       (state_q == S_SETUP),
    .wait_cycle ((state_q == S_ACCESS) && !bus.PREADY),
    .timeout    (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          paddr_d  = bus.req_addr;
          pwdata_d = bus.req_wdata;
          pwrite_d = bus.req_write;
          // Misaligned requests are answered locally without touching the bus.
          if (addr_misaligned(bus.req_addr[1:0])) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
            state_d     = S_RESP;
          end else begin
            psel_d  = 1'b1;
            state_d = S_SETUP;
          end
        end
      end

      S_SETUP: begin
        penable_d = 1'b1;
        state_d   = S_ACCESS;
      end

      S_ACCESS: begin
        if (bus.PREADY) begin
          rsp_rdata_d = pwrite_q ? '0 : bus.PRDATA;
          rsp_err_d   = bus.PSLVERR;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else if (timeout_hit) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end
      end

      S_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= S_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.PSEL      = psel_q;
  assign bus.PENABLE   = penable_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge; timeout steps run when APB_MASTER_TIMEOUT_EN is defined.
module tb_apb_master_bridge;

  logic pclk;
  logic preset;
  int   vectors;
  int   miscompares;

  apb_master_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  apb_master_bridge #(
    .ADDR_W        (32),
    .DATA_W        (32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .PCLK  (pclk),
    .PRESET(preset),
    .bus   (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    preset        = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    bus.PRDATA    = '0;
    bus.PREADY    = 1'b0;
    bus.PSLVERR   = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_psel", 32'(bus.PSEL), 32'd0);
    chk("rst_penable", 32'(bus.PENABLE), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_paddr", bus.PADDR, 32'h0);
    preset = 1'b0;

    // Write 0x10 = 0xDEADBEEF, zero wait states
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 32'h0000_0010;
    bus.req_wdata = 32'hDEAD_BEEF;
    bus.PREADY    = 1'b1;
    bus.PRDATA    = 32'hAAAA_5555;
    chk("wr_t0_req_ready", 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 1'b0;
    bus.req_addr  = 32'hFFFF_FFF0;
    bus.req_wdata = 32'h0;
    chk("wr_t1_psel", 32'(bus.PSEL), 32'd1);
    chk("wr_t1_penable", 32'(bus.PENABLE), 32'd0);
    chk("wr_t1_pwrite", 32'(bus.PWRITE), 32'd1);
    chk("wr_t1_paddr", bus.PADDR, 32'h0000_0010);
    chk("wr_t1_pwdata", bus.PWDATA, 32'hDEAD_BEEF);
    chk("wr_t1_req_ready", 32'(bus.req_ready), 32'd0);
    tick();
    chk("wr_t2_psel", 32'(bus.PSEL), 32'd1);
    chk("wr_t2_penable", 32'(bus.PENABLE), 32'd1);
    chk("wr_t2_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    tick();
    chk("wr_t3_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("wr_t3_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("wr_t3_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("wr_t3_psel", 32'(bus.PSEL), 32'd0);
    chk("wr_t3_penable", 32'(bus.PENABLE), 32'd0);
    bus.rsp_ready = 1'b1;
    tick();
    chk("wr_t4_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("wr_t4_req_ready", 32'(bus.req_ready), 32'd1);

    // Read 0x20 with 3 wait states
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 32'h0000_0020;
    bus.PREADY    = 1'b0;
    bus.PRDATA    = 32'h0BAD_0BAD;
    tick();
    bus.req_valid = 1'b0;
    bus.req_addr  = 32'h0000_0000;
    chk("rd_t1_pwrite", 32'(bus.PWRITE), 32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("rd_wait_psel", 32'(bus.PSEL), 32'd1);
      chk("rd_wait_penable", 32'(bus.PENABLE), 32'd1);
      chk("rd_wait_paddr", bus.PADDR, 32'h0000_0020);
      chk("rd_wait_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      tick();
    end
    bus.PREADY = 1'b1;
    bus.PRDATA = 32'h1234_5678;
    chk("rd_t5_paddr", bus.PADDR, 32'h0000_0020);
    chk("rd_t5_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    tick();
    bus.PRDATA = 32'h0;
    chk("rd_t6_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("rd_t6_rsp_rdata", bus.rsp_rdata, 32'h1234_5678);
    chk("rd_t6_rsp_err", 32'(bus.rsp_err), 32'd0);
    tick();
    chk("rd_t7_rsp_valid", 32'(bus.rsp_valid), 32'd0);

    // Read 0x04 with PSLVERR, response held by rsp_ready=0
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 32'h0000_0004;
    bus.PREADY    = 1'b0;
    tick();
    bus.req_valid = 1'b0;
    tick();
    bus.PREADY  = 1'b1;
    bus.PSLVERR = 1'b1;
    bus.PRDATA  = 32'hCAFE_F00D;
    tick();
    bus.PSLVERR   = 1'b0;
    bus.PRDATA    = 32'h0;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 32'h0000_0040;
    chk("err_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("err_rsp_err", 32'(bus.rsp_err), 32'd1);
    chk("err_rsp_rdata", bus.rsp_rdata, 32'hCAFE_F00D);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("hold_rsp_err", 32'(bus.rsp_err), 32'd1);
      chk("hold_rsp_rdata", bus.rsp_rdata, 32'hCAFE_F00D);
      chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
      chk("hold_psel", 32'(bus.PSEL), 32'd0);
      chk("hold_paddr", bus.PADDR, 32'h0000_0004);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
    chk("hold_rel_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("hold_rel_req_ready", 32'(bus.req_ready), 32'd1);
    tick();
    chk("hold_no_second_psel", 32'(bus.PSEL), 32'd0);

    // Misaligned address
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 32'h0000_0003;
    bus.PRDATA    = 32'h5A5A_5A5A;
    tick();
    bus.req_valid = 1'b0;
    chk("mis_psel", 32'(bus.PSEL), 32'd0);
    chk("mis_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("mis_rsp_err", 32'(bus.rsp_err), 32'd1);
    chk("mis_rsp_rdata", bus.rsp_rdata, 32'h0);
    bus.rsp_ready = 1'b1;
    tick();
    chk("mis_done_psel", 32'(bus.PSEL), 32'd0);
    chk("mis_done_rsp_valid", 32'(bus.rsp_valid), 32'd0);

    // Reset during ACCESS of a read
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0000_0030;
    bus.PREADY    = 1'b0;
    tick();
    bus.req_valid = 1'b0;
    tick();
    chk("rsta_access_penable", 32'(bus.PENABLE), 32'd1);
    preset = 1'b1;
    tick();
    chk("rsta_psel", 32'(bus.PSEL), 32'd0);
    chk("rsta_penable", 32'(bus.PENABLE), 32'd0);
    chk("rsta_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    preset     = 1'b0;
    bus.PREADY = 1'b1;
    tick();
    chk("rsta_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rsta_no_rsp", 32'(bus.rsp_valid), 32'd0);
    tick();
    chk("rsta_no_rsp_late", 32'(bus.rsp_valid), 32'd0);
    chk("rsta_no_psel_late", 32'(bus.PSEL), 32'd0);

`ifdef APB_MASTER_TIMEOUT_EN
    // Timeout: PREADY held low aborts after the 16th ACCESS cycle
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0000_0050;
    bus.PREADY    = 1'b0;
    bus.PRDATA    = 32'h7777_7777;
    tick();
    bus.req_valid = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) begin
      chk("tmo_access_psel", 32'(bus.PSEL), 32'd1);
      tick();
    end
    chk("tmo_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("tmo_rsp_err", 32'(bus.rsp_err), 32'd1);
    chk("tmo_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("tmo_psel", 32'(bus.PSEL), 32'd0);
    tick();

    // PREADY on exactly the 16th ACCESS cycle completes normally
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0000_0060;
    tick();
    bus.req_valid = 1'b0;
    tick();
    for (int i = 0; i < 15; i++) begin
      chk("tmo16_access_psel", 32'(bus.PSEL), 32'd1);
      tick();
    end
    bus.PREADY = 1'b1;
    bus.PRDATA = 32'h600D_F00D;
    chk("tmo16_still_access", 32'(bus.PENABLE), 32'd1);
    tick();
    chk("tmo16_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("tmo16_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("tmo16_rsp_rdata", bus.rsp_rdata, 32'h600D_F00D);
    tick();
`else
    // Without the timeout, ACCESS waits as long as PREADY stays low
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0000_0050;
    bus.PREADY    = 1'b0;
    tick();
    bus.req_valid = 1'b0;
    tick();
    for (int i = 0; i < 20; i++) begin
      chk("nto_access_psel", 32'(bus.PSEL), 32'd1);
      chk("nto_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      tick();
    end
    bus.PREADY = 1'b1;
    bus.PRDATA = 32'h600D_F00D;
    tick();
    chk("nto_rsp_valid_end", 32'(bus.rsp_valid), 32'd1);
    chk("nto_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("nto_rsp_rdata", bus.rsp_rdata, 32'h600D_F00D);
    tick();
`endif

    chk("end_req_ready", 32'(bus.req_ready), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
